// File: rtl/enoc_packet_source.sv
// ---------------------------------------------------------------------------
// enoc_packet_source
//
// Synthetic traffic source for one ENoC network input port. Packets are
// generated at a programmable period. Each one gets a pseudo-random
// destination that is never the local node, a sequence number and a
// generation timestamp. Packets wait in a small FIFO and are offered to the
// network with a valid/enable handshake.
//
// Ports:
//   clk          clock
//   reset_n      asynchronous active-low reset
//   i_enable     generation enable
//   i_rate       injection period minus 1 (0 = one packet per cycle)
//   i_en         network ready to accept the head packet
//   o_data_val   FIFO head valid
//   o_src        local node id (constant)
//   o_dest       destination of the head packet
//   o_seq        sequence number of the head packet
//   o_ts         generation timestamp of the head packet
//   o_sent_cnt   completed handshakes (wraps)
//   o_drop_cnt   packets dropped on a full FIFO (saturates)
//   o_full       FIFO full
// ---------------------------------------------------------------------------
module enoc_packet_source #(
  parameter int          NODE_ID = 0,
  parameter int          X_NODES = 4,
  parameter int          Y_NODES = 4,
  parameter int          DEPTH   = 4,
  parameter int          RATE_W  = 8,
  parameter logic [15:0] SEED    = 16'hACE1,
  localparam int         N       = X_NODES * Y_NODES,
  localparam int         DEST_W  = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_enable,
  input  logic [RATE_W-1:0] i_rate,
  input  logic              i_en,
  output logic              o_data_val,
  output logic [DEST_W-1:0] o_src,
  output logic [DEST_W-1:0] o_dest,
  output logic [15:0]       o_seq,
  output logic [31:0]       o_ts,
  output logic [31:0]       o_sent_cnt,
  output logic [15:0]       o_drop_cnt,
  output logic              o_full
);

  localparam int              PTR_W     = $clog2(DEPTH);
  localparam logic [15:0]     LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0]     LFSR_MASK = 16'hB400;
  localparam logic [DEST_W-1:0] NODE    = DEST_W'(NODE_ID);
  localparam logic [DEST_W-1:0] LAST    = DEST_W'(N - 1);
  // Truncated N: subtracting it modulo 2^DEST_W folds d0 back into 0..N-1.
  localparam logic [DEST_W-1:0] N_TRUNC = DEST_W'(N);

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [15:0]       seq;
    logic [31:0]       ts;
  } entry_t;

  logic [31:0]       ts_q;
  logic [RATE_W-1:0] pc_q;
  logic [15:0]       lfsr_q;
  logic [15:0]       seq;
  logic [31:0]       sent_cnt;
  logic [15:0]       drop_cnt;
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  entry_t            mem [DEPTH];

  logic              gen;
  logic              deq;
  logic              enq;
  logic              drop;
  logic              empty;
  logic              full;
  logic [15:0]       lfsr_next;
  logic [DEST_W-1:0] d0;
  logic [DEST_W-1:0] dest;
  entry_t            head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  // >= rather than == lets a lowered period take effect mid-count.
  assign gen  = i_enable && (pc_q >= i_rate);
  assign deq  = !empty && i_en;
  // A dequeue in the same cycle frees a slot, so a full FIFO still accepts.
  assign enq  = gen && (!full || deq);
  assign drop = gen && full && !deq;

  assign lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);

  // Destination: fold the raw LFSR bits into 0..N-1, then bump past the
  // local node. The node after NODE_ID is therefore picked twice as often.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    d0   = lfsr_q[DEST_W-1:0];
    dest = '0;
    if (d0 > LAST) begin
      d0 = d0 - N_TRUNC;
    end
    if (d0 == NODE) begin
      dest = (d0 == LAST) ? '0 : d0 + DEST_W'(1);
    end else begin
      dest = d0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_q     <= '0;
      pc_q     <= '0;
      lfsr_q   <= LFSR_INIT;
      seq      <= '0;
      sent_cnt <= '0;
      drop_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      ts_q <= ts_q + 32'd1;

      if (!i_enable || gen) begin
        pc_q <= '0;
      end else begin
        pc_q <= pc_q + RATE_W'(1);
      end

      // The LFSR advances on every generation, dropped or not.
      if (gen) begin
        lfsr_q <= lfsr_next;
      end

      if (enq) begin
        seq    <= seq + 16'd1;
        wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      end

      if (deq) begin
        rd_ptr   <= rd_ptr + (PTR_W+1)'(1);
        sent_cnt <= sent_cnt + 32'd1;
      end

      if (drop && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // NOTE: the storage array is reset here on purpose. It is only DEPTH
  // entries, and clearing it makes the head outputs read zero during and
  // straight after reset instead of showing stale packets.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (enq) begin
      mem[wr_ptr[PTR_W-1:0]] <= '{dest: dest, seq: seq, ts: ts_q};
    end
  end

  assign head       = mem[rd_ptr[PTR_W-1:0]];
  assign o_data_val = !empty;
  assign o_full     = full;
  assign o_src      = NODE;
  assign o_dest     = head.dest;
  assign o_seq      = head.seq;
  assign o_ts       = head.ts;
  assign o_sent_cnt = sent_cnt;
  assign o_drop_cnt = drop_cnt;

endmodule

// File: tb/tb_enoc_packet_source.sv
// ---------------------------------------------------------------------------
// tb_enoc_packet_source
//
// Self-checking bench for enoc_packet_source (NODE_ID=5 on a 4x4 mesh,
// DEPTH=4). A transaction-level model (packet queue, counters, LFSR function)
// runs alongside the DUT. A table of hand-derived vectors covers fill, drop
// and full-with-dequeue. Hand-written sequences cover reset, the injection
// period, counter wrap/saturation and destination statistics. A randomized
// phase finishes the run.
// ---------------------------------------------------------------------------
module tb_enoc_packet_source;

  localparam int NODE_ID = 5;
  localparam int XN      = 4;
  localparam int YN      = 4;
  localparam int N       = XN * YN;
  localparam int DW      = $clog2(N);
  localparam int DEPTH   = 4;
  localparam int RATE_W  = 8;

  logic              clk;
  logic              reset_n;
  logic              i_enable;
  logic [RATE_W-1:0] i_rate;
  logic              i_en;
  logic              o_data_val;
  logic [DW-1:0]     o_src;
  logic [DW-1:0]     o_dest;
  logic [15:0]       o_seq;
  logic [31:0]       o_ts;
  logic [31:0]       o_sent_cnt;
  logic [15:0]       o_drop_cnt;
  logic              o_full;

  enoc_packet_source #(
    .NODE_ID (NODE_ID),
    .X_NODES (XN),
    .Y_NODES (YN),
    .DEPTH   (DEPTH),
    .RATE_W  (RATE_W),
    .SEED    (16'hACE1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_enable   (i_enable),
    .i_rate     (i_rate),
    .i_en       (i_en),
    .o_data_val (o_data_val),
    .o_src      (o_src),
    .o_dest     (o_dest),
    .o_seq      (o_seq),
    .o_ts       (o_ts),
    .o_sent_cnt (o_sent_cnt),
    .o_drop_cnt (o_drop_cnt),
    .o_full     (o_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------------
  // Reference model: packets live in a queue; generation is "at least
  // i_rate idle cycles have elapsed since the last packet".
  // ------------------------------------------------------------------------
  typedef struct {
    logic [DW-1:0] dest;
    logic [15:0]   seq;
    logic [31:0]   ts;
  } pkt_t;

  pkt_t        mq[$];
  logic [31:0] m_ts;
  int          m_idle;
  logic [15:0] m_lfsr;
  logic [15:0] m_seq;
  logic [15:0] m_drop;
  logic [31:0] m_sent;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  function automatic logic [DW-1:0] pick_dest(input logic [15:0] l);
    int d;
    d = int'(l) % (1 << DW);
    if (d >= N) d -= N;
    if (d == NODE_ID) d = (d == N - 1) ? 0 : d + 1;
    return DW'(d);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ts   = '0;
    m_idle = 0;
    m_lfsr = 16'hACE1;
    m_seq  = '0;
    m_drop = '0;
    m_sent = '0;
  endtask

  // Applies one clock edge's worth of behaviour using the current inputs.
  task automatic model_edge();
    bit   gen, deq, was_full;
    pkt_t p;
    was_full = (mq.size() == DEPTH);
    deq      = (mq.size() > 0) && i_en;
    gen      = i_enable && (m_idle >= int'(i_rate));
    if (deq) begin
      void'(mq.pop_front());
      m_sent++;
    end
    if (gen) begin
      if (!was_full || deq) begin
        p.dest = pick_dest(m_lfsr);
        p.seq  = m_seq;
        p.ts   = m_ts;
        mq.push_back(p);
        m_seq++;
      end else if (m_drop != 16'hFFFF) begin
        m_drop++;
      end
      m_lfsr = lfsr_step(m_lfsr);
    end
    m_idle = (!i_enable || gen) ? 0 : m_idle + 1;
    m_ts++;
  endtask

  task automatic compare_model();
    check("data_val", o_data_val, mq.size() > 0);
    check("full", o_full, mq.size() == DEPTH);
    check("sent_cnt", o_sent_cnt, m_sent);
    check("drop_cnt", o_drop_cnt, m_drop);
    check("src", o_src, NODE_ID);
    if (mq.size() > 0) begin
      check("dest", o_dest, mq[0].dest);
      check("seq", o_seq, mq[0].seq);
      check("ts", o_ts, mq[0].ts);
    end
  endtask

  // Inputs are set at the falling edge; outputs are checked at the next one.
  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_val"},  o_data_val, 0);
    check({tag, "_full"}, o_full, 0);
    check({tag, "_dest"}, o_dest, 0);
    check({tag, "_seq"},  o_seq, 0);
    check({tag, "_ts"},   o_ts, 0);
    check({tag, "_sent"}, o_sent_cnt, 0);
    check({tag, "_drop"}, o_drop_cnt, 0);
  endtask

  // Asserts reset asynchronously mid-cycle and checks outputs at once.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Directed vectors: i_enable=1, i_rate=0 from reset, i_en low for 10
  // cycles and then high. Row k is cycle k after release (ts=k).
  typedef struct {
    logic        en;
    logic        exp_val;
    logic        exp_full;
    logic [15:0] exp_seq;
    logic [31:0] exp_ts;
    logic [15:0] exp_drop;
    logic [31:0] exp_sent;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int          hs;
    logic [15:0] prev_seq;
    logic [31:0] prev_ts;
    int          hist[N];
    int          others;

    tbl[0]  = '{1'b0, 1'b1, 1'b0, 16'd0, 32'd0,  16'd0, 32'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 16'd0, 32'd0,  16'd0, 32'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 16'd0, 32'd0,  16'd0, 32'd0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 16'd0, 32'd0,  16'd0, 32'd0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 16'd0, 32'd0,  16'd1, 32'd0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 16'd0, 32'd0,  16'd2, 32'd0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 16'd0, 32'd0,  16'd3, 32'd0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 16'd0, 32'd0,  16'd4, 32'd0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 16'd0, 32'd0,  16'd5, 32'd0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 16'd0, 32'd0,  16'd6, 32'd0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 16'd1, 32'd1,  16'd6, 32'd1};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 16'd2, 32'd2,  16'd6, 32'd2};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 16'd3, 32'd3,  16'd6, 32'd3};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 16'd4, 32'd10, 16'd6, 32'd4};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 16'd5, 32'd11, 16'd6, 32'd5};

    // Power-on reset.
    reset_n  = 1'b0;
    i_enable = 1'b0;
    i_rate   = '0;
    i_en     = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("por");
    reset_n = 1'b1;

    // Fill, drop, then full with simultaneous dequeue.
    i_enable = 1'b1;
    i_rate   = '0;
    for (int k = 0; k < 15; k++) begin
      i_en = tbl[k].en;
      step();
      check($sformatf("tbl%0d_val", k),  o_data_val, tbl[k].exp_val);
      check($sformatf("tbl%0d_full", k), o_full,     tbl[k].exp_full);
      check($sformatf("tbl%0d_seq", k),  o_seq,      tbl[k].exp_seq);
      check($sformatf("tbl%0d_ts", k),   o_ts,       tbl[k].exp_ts);
      check($sformatf("tbl%0d_drop", k), o_drop_cnt, tbl[k].exp_drop);
      check($sformatf("tbl%0d_sent", k), o_sent_cnt, tbl[k].exp_sent);
    end

    // Reset while the FIFO is full and traffic is flowing.
    do_reset();

    // Period 4 (i_rate=3): handshakes 4 cycles apart, ts gap 4.
    i_enable = 1'b1;
    i_rate   = 8'd3;
    i_en     = 1'b1;
    hs       = 0;
    prev_seq = '0;
    prev_ts  = '0;
    for (int c = 0; c < 40; c++) begin
      if (o_data_val) begin
        if (hs == 0) begin
          check("period_first_seq", o_seq, 0);
          check("period_first_ts", o_ts, 3);
        end else begin
          check("period_seq_step", o_seq, prev_seq + 16'd1);
          check("period_ts_gap", o_ts - prev_ts, 4);
        end
        prev_seq = o_seq;
        prev_ts  = o_ts;
        hs++;
      end
      step();
    end
    check("period_handshakes", hs, 9);

    // Sequence number wrap.
    i_enable = 1'b0;
    repeat (3) step();
    force dut.seq = 16'hFFFF;
    #1;
    release dut.seq;
    m_seq    = 16'hFFFF;
    i_enable = 1'b1;
    i_rate   = '0;
    step();
    check("seq_at_ffff", o_seq, 16'hFFFF);
    step();
    check("seq_wrapped", o_seq, 16'h0000);

    // Drop counter saturation.
    i_en = 1'b0;
    repeat (6) step();
    check("sat_full", o_full, 1);
    force dut.drop_cnt = 16'hFFFE;
    #1;
    release dut.drop_cnt;
    m_drop = 16'hFFFE;
    step();
    check("drop_reach_ffff", o_drop_cnt, 16'hFFFF);
    step();
    check("drop_saturated", o_drop_cnt, 16'hFFFF);

    // Destination legality and distribution over 10000 packets.
    do_reset();
    i_enable = 1'b1;
    i_rate   = '0;
    i_en     = 1'b1;
    for (int d = 0; d < N; d++) hist[d] = 0;
    for (int c = 0; c < 10000; c++) begin
      if (o_data_val) begin
        check("dest_not_local", o_dest != NODE_ID, 1);
        check("dest_in_range", int'(o_dest) < N, 1);
        hist[o_dest]++;
      end
      step();
      check("stream_never_full", o_full, 0);
    end
    check("stream_sent", o_sent_cnt, 9999);
    check("hist_local_zero", hist[NODE_ID], 0);
    others = 0;
    for (int d = 0; d < N; d++) begin
      if (d != NODE_ID && d != NODE_ID + 1) others += hist[d];
    end
    // Average of the other 14 destinations; the bumped one should be ~2x.
    check("hist_next_ratio_lo", hist[NODE_ID + 1] * 14 * 10 > others * 15, 1);
    check("hist_next_ratio_hi", hist[NODE_ID + 1] * 14 * 10 < others * 25, 1);

    // Randomized traffic against the model, with one reset in the middle.
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) begin
        i_rate   = RATE_W'($urandom_range(0, 6));
        i_enable = ($urandom_range(0, 9) != 0);
      end
      i_en = ($urandom_range(0, 9) < 6);
      if (c == 2000) do_reset();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
